reg_data_mem_param: RTL and testbench
=====================================

# reg_data_mem_param

Parametrised, clocked register-file data memory for the datapath's load/store stage, replacing the fixed 16x16 combinational-latch memory. It provides synchronous writes, a registered read port with a valid strobe and out-of-range detection, and a background clear sweep. It also has a multi-word monitor window for the display/debug path that can be selected directly or auto-stepped.

## Interface
- DATA_W, 16: word width in bits.
- ADDR_W, 4: internal address bits; DEPTH = 2**ADDR_W words.
- AIN_W, 16: width of the incoming address bus; AIN_W >= ADDR_W.
- MON_WORDS, 2: consecutive words concatenated on the monitor port; 1..DEPTH.

- clk  in  1  single clock, rising edge.
- nClear  in  1  asynchronous active-low reset; clears all storage and state.
- addr  in  AIN_W  word address for read/write.
- data_in  in  DATA_W  write data.
- MemWrite  in  1  write strobe, sampled at clk edge.
- MemRead  in  1  read strobe, sampled at clk edge.
- clr_req  in  1  single-cycle pulse that starts a synchronous clear sweep.
- mon_auto  in  1  1 = monitor base advances on mon_step; 0 = base follows mon_sel.
- mon_step  in  1  advance auto monitor base by one (wraps).
- mon_sel  in  ADDR_W  direct monitor base address.
- data_out  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse: data_out updated by a read.
- addr_err  out  1  one-cycle pulse: access with addr >= DEPTH.
- busy  out  1  clear sweep in progress.
- m_data  out  DATA_W*MON_WORDS  monitor window, lowest address in MSBs.
- m_base  out  ADDR_W  base address currently shown on m_data.

## Operation
- Reset (nClear=0, async): all words 0; data_out, rd_valid, addr_err, busy, m_data, m_base, sweep pointer, auto pointer all 0; FSM to IDLE. Applies mid-sweep too.
- Write: MemWrite=1, busy=0, addr < DEPTH -> mem[addr] <= data_in at edge.
- Read: MemRead=1 -> at edge, data_out <= mem[addr]; rd_valid=1 next cycle. data_out holds otherwise.
- Read and write to the same address in one cycle: write-first; data_out gets data_in.
- Out of range (addr >= DEPTH, any upper bits set): write dropped; read gives data_out=0, rd_valid=1; addr_err=1 for any MemRead or MemWrite at such addr.
- Clear FSM, states IDLE/SWEEP:
  - IDLE + clr_req -> SWEEP, pointer=0.
  - SWEEP: mem[pointer] <= 0 each cycle; pointer increments.
  - After pointer = DEPTH-1 is cleared -> IDLE.
  - clr_req during SWEEP is ignored.
  - MemWrite during SWEEP is dropped, without addr_err.
  - MemRead during SWEEP returns data_out=0 with rd_valid=1.
- Monitor:
  - Base = mon_sel when mon_auto=0; otherwise auto pointer, which increments mod DEPTH on each cycle with mon_step=1.
  - m_data word k = mem[(base+k) mod DEPTH], k=0..MON_WORDS-1, word 0 in MSBs.

## Timing
- Write visible to a read issued the following cycle; data_out is valid 1 cycle after the MemRead edge.
- m_data/m_base registered: reflect memory and base as of the previous edge (1-cycle latency, updated every cycle).
- busy rises the cycle after clr_req and stays high exactly DEPTH cycles.
- rd_valid and addr_err are never high for more than one cycle per strobe cycle.
- Auto pointer retains its value when mon_auto toggles; it is reset only by nClear.

## Test plan
- Reset, write 0xA5A5 to 3, read 3 -> data_out=0xA5A5, rd_valid high exactly one cycle after the read edge.
- Simultaneous MemWrite+MemRead at addr 7 with data_in 0x1234 (old 0x0000) -> data_out=0x1234.
- Read/write at addr 0x0010 (DEPTH=16) -> addr_err pulses, data_out=0, mem[0] unchanged.
- Fill all words, pulse clr_req -> busy high 16 cycles; write at cycle 5 dropped; after the sweep every read returns 0; a second clr_req mid-sweep does not extend busy.
- mon_auto=1, base 15, MON_WORDS=2, one mon_step -> m_data={mem[0],mem[1]}, m_base=0; previous window {mem[15],mem[0]}.
- Assert nClear mid-sweep at pointer 8 -> busy=0 and all outputs 0 immediately; after release the FSM is IDLE and mem is all 0.

Source files
------------

// File: rtl/reg_data_mem_param_if.sv
// Bus bundle for reg_data_mem_param: access strobes, clear request, monitor controls and
// read/monitor results. The master drives requests; the memory is the slave.
interface reg_data_mem_param_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned AIN_W     = 16,
    parameter int unsigned MON_WORDS = 2
);
    logic [AIN_W-1:0]            addr;
    logic [DATA_W-1:0]           data_in;
    logic                        MemWrite;
    logic                        MemRead;
    logic                        clr_req;
    logic                        mon_auto;
    logic                        mon_step;
    logic [ADDR_W-1:0]           mon_sel;
    logic [DATA_W-1:0]           data_out;
    logic                        rd_valid;
    logic                        addr_err;
    logic                        busy;
    logic [DATA_W*MON_WORDS-1:0] m_data;
    logic [ADDR_W-1:0]           m_base;

    modport master (
        output addr, data_in, MemWrite, MemRead, clr_req, mon_auto, mon_step, mon_sel,
        input  data_out, rd_valid, addr_err, busy, m_data, m_base
    );

    modport slave (
        input  addr, data_in, MemWrite, MemRead, clr_req, mon_auto, mon_step, mon_sel,
        output data_out, rd_valid, addr_err, busy, m_data, m_base
    );
endinterface

// File: rtl/reg_data_mem_param.sv
// Clocked register-file data memory: synchronous write, registered read with valid/range
// strobes, background clear sweep and a registered multi-word monitor window.
module reg_data_mem_param #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned AIN_W     = 16,
    parameter int unsigned MON_WORDS = 2
) (
    input logic                 clk,
    input logic                 nClear,
    reg_data_mem_param_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {StIdle, StSweep} state_e;

    state_e                      state_q, state_d;
    logic [ADDR_W-1:0]           sweep_ptr_q, sweep_ptr_d;
    logic [ADDR_W-1:0]           auto_ptr_q, auto_ptr_d;
    logic [ADDR_W-1:0]           m_base_q, m_base_d;
    logic [DATA_W-1:0]           mem_q [DEPTH];
    logic [DATA_W-1:0]           mem_d [DEPTH];
    logic [DATA_W-1:0]           data_out_q, data_out_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        addr_err_q, addr_err_d;
    logic [DATA_W*MON_WORDS-1:0] m_data_q, m_data_d;

    logic [AIN_W-1:0]  addr_hi;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] win_idx;
    logic              in_range;
    logic              sweeping;

    assign addr_hi  = bus.addr >> ADDR_W;
    assign in_range = (addr_hi == '0);
    assign idx      = bus.addr[ADDR_W-1:0];
    assign sweeping = (state_q == StSweep);
    assign base     = bus.mon_auto ? auto_ptr_q : bus.mon_sel;

    // Clear FSM: one word zeroed per cycle, leaves after the last index is cleared.
    always_comb begin
        state_d     = state_q;
        sweep_ptr_d = sweep_ptr_q;
        case (state_q)
            StIdle: begin
                if (bus.clr_req) begin
                    state_d     = StSweep;
                    sweep_ptr_d = '0;
                end
            end
            StSweep: begin
                sweep_ptr_d = sweep_ptr_q + 1'b1;
                if (&sweep_ptr_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (sweeping) begin
            mem_d[sweep_ptr_q] = '0;
        end else if (bus.MemWrite && in_range) begin
            mem_d[idx] = bus.data_in;
        end
    end

    // Read path is write-first; sweeps and out-of-range reads return zero.
    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = bus.MemRead;
        addr_err_d = !in_range && (bus.MemRead || (bus.MemWrite && !sweeping));
        if (bus.MemRead) begin
            if (sweeping || !in_range) begin
                data_out_d = '0;
            end else if (bus.MemWrite) begin
                data_out_d = bus.data_in;
            end else begin
                data_out_d = mem_q[idx];
            end
        end
    end

    always_comb begin
        auto_ptr_d = auto_ptr_q;
        if (bus.mon_auto && bus.mon_step) auto_ptr_d = auto_ptr_q + 1'b1;
        m_base_d = base;
        m_data_d = '0;
        win_idx  = base;
        for (int k = 0; k < int'(MON_WORDS); k++) begin
            win_idx = base + ADDR_W'(k);
            m_data_d[DATA_W*(MON_WORDS-1-k) +: DATA_W] = mem_q[win_idx];
        end
    end

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            state_q     <= StIdle;
            sweep_ptr_q <= '0;
            auto_ptr_q  <= '0;
            m_base_q    <= '0;
            mem_q       <= '{default: '0};
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            m_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            sweep_ptr_q <= sweep_ptr_d;
            auto_ptr_q  <= auto_ptr_d;
            m_base_q    <= m_base_d;
            mem_q       <= mem_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            addr_err_q  <= addr_err_d;
            m_data_q    <= m_data_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.addr_err = addr_err_q;
    assign bus.busy     = sweeping;
    assign bus.m_data   = m_data_q;
    assign bus.m_base   = m_base_q;
endmodule

// File: tb/tb_reg_data_mem_param.sv
// Scoreboard bench for reg_data_mem_param: directed scenarios followed by random traffic,
// checked against an array-based model of the memory, clear sweep and monitor window.
module tb_reg_data_mem_param;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 4;
    localparam int AIN_W     = 16;
    localparam int MON_WORDS = 2;
    localparam int DEPTH     = 16;

    logic clk = 1'b0;
    logic nClear;
    always #5 clk = ~clk;

    reg_data_mem_param_if #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AIN_W(AIN_W), .MON_WORDS(MON_WORDS)
    ) bus ();

    reg_data_mem_param #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AIN_W(AIN_W), .MON_WORDS(MON_WORDS)
    ) dut (
        .clk   (clk),
        .nClear(nClear),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] rd_exp_q[$];
    logic [DATA_W-1:0] mdl_mem[DEPTH];
    int                sweep_left;
    int                sweep_idx;
    int                auto_ptr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every read strobe must match the oldest outstanding expected read.
    always @(negedge clk) begin
        if (nClear === 1'b1 && bus.rd_valid === 1'b1) begin
            checks++;
            if (rd_exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_valid_unexpected: got data_out 0x%0h with no read pending",
                         bus.data_out);
            end else begin
                logic [DATA_W-1:0] e;
                e = rd_exp_q.pop_front();
                checks--;
                chk("read_data", bus.data_out, e);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        sweep_left = 0;
        sweep_idx  = 0;
        auto_ptr   = 0;
        rd_exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_data_out"}, bus.data_out, 0);
        chk({tag, "_rd_valid"}, bus.rd_valid, 0);
        chk({tag, "_addr_err"}, bus.addr_err, 0);
        chk({tag, "_m_data"}, bus.m_data, 0);
        chk({tag, "_m_base"}, bus.m_base, 0);
    endtask

    // One clock edge: predict from the pre-edge model, update it, then compare outputs.
    task automatic step();
        logic                        inr, s, rd, wr, exp_err;
        int                          a, exp_base;
        logic [DATA_W*MON_WORDS-1:0] exp_md;
        @(posedge clk);
        a   = int'(bus.addr);
        inr = (a < DEPTH);
        s   = (sweep_left > 0);
        rd  = bus.MemRead;
        wr  = bus.MemWrite;
        if (rd) begin
            if (s || !inr) rd_exp_q.push_back('0);
            else if (wr)   rd_exp_q.push_back(bus.data_in);
            else           rd_exp_q.push_back(mdl_mem[a]);
        end
        exp_err  = !inr && (rd || (wr && !s));
        exp_base = bus.mon_auto ? auto_ptr : int'(bus.mon_sel);
        exp_md   = '0;
        for (int k = 0; k < MON_WORDS; k++) begin
            exp_md = (exp_md << DATA_W) | {{DATA_W{1'b0}}, mdl_mem[(exp_base + k) % DEPTH]};
        end
        if (s) begin
            mdl_mem[sweep_idx] = '0;
            sweep_idx++;
            sweep_left--;
        end else begin
            if (bus.clr_req) begin
                sweep_left = DEPTH;
                sweep_idx  = 0;
            end
            if (wr && inr) mdl_mem[a] = bus.data_in;
        end
        if (bus.mon_auto && bus.mon_step) auto_ptr = (auto_ptr + 1) % DEPTH;
        #1;
        chk("busy", bus.busy, (sweep_left > 0));
        chk("rd_valid", bus.rd_valid, rd);
        chk("addr_err", bus.addr_err, exp_err);
        chk("m_base", bus.m_base, exp_base);
        chk("m_data", bus.m_data, exp_md);
        @(negedge clk);
    endtask

    task automatic cyc(input bit wr, input bit rd, input int a, input int d, input bit clr);
        bus.MemWrite = wr;
        bus.MemRead  = rd;
        bus.addr     = AIN_W'(a);
        bus.data_in  = DATA_W'(d);
        bus.clr_req  = clr;
        step();
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b0;
        bus.clr_req  = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        nClear = 1'b0;
        #1;
        chk_all_zero(tag);
        model_reset();
        #1;
        nClear = 1'b1;
    endtask

    task automatic fill_all();
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, i, int'($urandom_range(1, 16'hFFFF)), 0);
    endtask

    initial begin
        nClear       = 1'b0;
        bus.addr     = '0;
        bus.data_in  = '0;
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b0;
        bus.clr_req  = 1'b0;
        bus.mon_auto = 1'b0;
        bus.mon_step = 1'b0;
        bus.mon_sel  = '0;
        model_reset();
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        nClear = 1'b1;

        // Basic write then read, and write-first on a combined access.
        cyc(1, 0, 3, 16'hA5A5, 0);
        cyc(0, 1, 3, 0, 0);
        cyc(1, 1, 7, 16'h1234, 0);
        cyc(0, 0, 0, 0, 0);

        // Out-of-range accesses must not alias onto word 0.
        cyc(1, 0, 16'h0010, 16'hFFFF, 0);
        cyc(0, 1, 16'h0010, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 16'h8003, 16'h5555, 0);
        cyc(0, 1, 3, 0, 0);

        // Auto monitor: walk base to 15, then one step wraps the window to {mem[0], mem[1]}.
        fill_all();
        bus.mon_auto = 1'b1;
        bus.mon_step = 1'b1;
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0);
        bus.mon_step = 1'b0;
        cyc(0, 0, 0, 0, 0);
        bus.mon_step = 1'b1;
        cyc(0, 0, 0, 0, 0);
        bus.mon_step = 1'b0;
        cyc(0, 0, 0, 0, 0);
        bus.mon_auto = 1'b0;
        bus.mon_sel  = 4'd9;
        cyc(0, 0, 0, 0, 0);
        bus.mon_auto = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // Clear sweep with a dropped write, an ignored second request and a read mid-sweep.
        fill_all();
        cyc(0, 0, 0, 0, 1);
        for (int c = 1; c <= 20; c++) begin
            if (c == 5)       cyc(1, 0, 2, 16'hFFFF, 0);
            else if (c == 8)  cyc(0, 0, 0, 0, 1);
            else if (c == 10) cyc(0, 1, 15, 0, 0);
            else              cyc(0, 0, 0, 0, 0);
        end
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, i, 0, 0);

        // Reset in the middle of a sweep.
        fill_all();
        cyc(0, 0, 0, 0, 1);
        while (sweep_idx < 8) cyc(0, 0, 0, 0, 0);
        do_reset("mid_sweep_reset");
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, i, 0, 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            int a;
            if ($urandom_range(0, 7) == 0) a = int'(($urandom_range(1, 4095) << 4) | $urandom_range(0, 15));
            else                           a = int'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 15) == 0) bus.mon_auto = ~bus.mon_auto;
            bus.mon_step = 1'($urandom_range(0, 1));
            bus.mon_sel  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 699) == 0) do_reset("rand_reset");
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                int'($urandom_range(0, 16'hFFFF)), ($urandom_range(0, 59) == 0));
        end
        cyc(0, 0, 0, 0, 0);

        checks++;
        if (rd_exp_q.size() != 0) begin
            errors++;
            $display("FAIL reads_outstanding: got %0d unanswered reads, expected 0",
                     rd_exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
